// File: rtl/ifetch.sv
// Instruction fetch stage: reads variable-length (2/6 byte) instructions from the
// unified RAM, advances the PC, and queues them toward decode with valid/ready.
module ifetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  input  logic [63:0] mem_q,
  input  logic        mem_busy,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [47:0] instr,
  output logic [2:0]  instr_len,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        halted
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]   r_pc;
  logic          r_halted;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [47:0]   r_q_instr [DEPTH];
  logic [2:0]    r_q_len   [DEPTH];
  logic [15:0]   r_q_pc    [DEPTH];

  logic [7:0]    w_op;
  logic [2:0]    w_len;
  logic [47:0]   w_instr;
  logic          w_halt_op;
  logic          w_full;
  logic          w_empty;
  logic          w_fetch;
  logic          w_pop;

  // Opcode bit 0 selects the long (6-byte) format; short instructions are zero-extended.
  assign w_op      = mem_q[7:0];
  assign w_len     = w_op[0] ? 3'd6 : 3'd2;
  assign w_instr   = w_op[0] ? mem_q[47:0] : {32'h0, mem_q[15:0]};
  assign w_halt_op = (w_op == 8'h00);

  // Fullness comes from the registered count only, so a same-cycle pop never frees a slot.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_fetch = !rst && !redirect && !mem_busy && !r_halted && !w_full;
  assign w_pop   = !rst && !redirect && !w_empty && instr_ready;

  assign mem_addr = r_pc;
  assign halted   = r_halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else if (redirect) begin
      r_pc     <= redirect_pc;
      r_halted <= 1'b0;
    end else if (w_fetch) begin
      r_pc <= r_pc + {13'b0, w_len};
      if (w_halt_op) begin
        r_halted <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_fetch) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_fetch, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payloads need no reset: they are masked by the empty flag until written.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (w_fetch && (r_wr_ptr == AW'(gi))) begin
          r_q_instr[gi] <= w_instr;
          r_q_len[gi]   <= w_len;
          r_q_pc[gi]    <= r_pc;
        end
      end
    end
  endgenerate

  always_comb begin
    instr       = '0;
    instr_len   = '0;
    instr_pc    = '0;
    instr_valid = !w_empty;
    if (!w_empty) begin
      instr     = r_q_instr[r_rd_ptr];
      instr_len = r_q_len[r_rd_ptr];
      instr_pc  = r_q_pc[r_rd_ptr];
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed testbench for ifetch: program run, backpressure, mem_busy, redirect,
// halt release, PC wrap and mid-run reset against a byte-array RAM model.
module tb_ifetch;

  logic        clk;
  logic        rst;
  logic [15:0] mem_addr;
  logic [63:0] mem_q;
  logic        mem_busy;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [47:0] instr;
  logic [2:0]  instr_len;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        halted;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [0:65535];
  logic [7:0] prog [0:27] = '{
    8'h41, 8'h06, 8'hF8, 8'hFF, 8'h00, 8'h00,
    8'h85, 8'h06, 8'h08, 8'h00, 8'h00, 8'h00,
    8'h05, 8'h00, 8'h2A, 8'h00, 8'h00, 8'h00,
    8'h08, 8'h00,
    8'h81, 8'h06, 8'h08, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00};

  ifetch #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_q(mem_q),
    .mem_busy(mem_busy), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_len(instr_len), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational little-endian RAM read, addresses wrap at 16 bits.
  always_comb begin
    mem_q = '0;
    for (int k = 0; k < 8; k++) begin
      mem_q[8*k +: 8] = mem[16'(mem_addr + 16'(k))];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a valid head, checks it, then advances one cycle.
  task automatic expect_instr(input logic [15:0] pc, input logic [2:0] len, input logic [47:0] ins);
    for (int i = 0; i < 20 && !instr_valid; i++) step();
    check("valid", 64'(instr_valid), 64'd1);
    check($sformatf("pc@%h", pc), 64'(instr_pc), 64'(pc));
    check($sformatf("len@%h", pc), 64'(instr_len), 64'(len));
    check($sformatf("instr@%h", pc), 64'(instr), 64'(ins));
    $display("instr pc=%h len=%0d instr=%h", instr_pc, instr_len, instr);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    for (int a = 0; a < 28; a++) mem[a] = prog[a];
    mem[16'hFFFE] = 8'h08;
    mem[16'hFFFF] = 8'h00;
    rst = 1'b1; mem_busy = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    step();
    rst = 1'b0;

    // Reset state
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_len", 64'(instr_len), 64'd0);
    check("rst_pc", 64'(instr_pc), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);

    // Program run with instr_ready held high
    expect_instr(16'd0,  3'd6, 48'h0000FFF80641);
    expect_instr(16'd6,  3'd6, 48'h000000080685);
    expect_instr(16'd12, 3'd6, 48'h0000002A0005);
    expect_instr(16'd18, 3'd2, 48'h000000000008);
    expect_instr(16'd20, 3'd6, 48'h000000080681);
    expect_instr(16'd26, 3'd2, 48'h000000000000);
    check("run_halted", 64'(halted), 64'd1);
    check("run_addr", 64'(mem_addr), 64'd28);
    step(); step();
    check("run_addr_hold", 64'(mem_addr), 64'd28);
    check("run_drained", 64'(instr_valid), 64'd0);

    // Backpressure
    instr_ready = 1'b0;
    do_reset();
    step(); step(); step();
    check("bp_addr", 64'(mem_addr), 64'd12);
    check("bp_head", 64'(instr_pc), 64'd0);
    instr_ready = 1'b1;
    expect_instr(16'd0,  3'd6, 48'h0000FFF80641);
    expect_instr(16'd6,  3'd6, 48'h000000080685);
    expect_instr(16'd12, 3'd6, 48'h0000002A0005);

    // mem_busy stall
    do_reset();
    step();
    check("busy_addr0", 64'(mem_addr), 64'd6);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("busy_addr_hold", 64'(mem_addr), 64'd6);
    end
    check("busy_empty", 64'(instr_valid), 64'd0);
    mem_busy = 1'b0;
    expect_instr(16'd6,  3'd6, 48'h000000080685);
    expect_instr(16'd12, 3'd6, 48'h0000002A0005);

    // Redirect with two entries queued
    instr_ready = 1'b0;
    do_reset();
    step(); step();
    check("rd_full_valid", 64'(instr_valid), 64'd1);
    check("rd_full_addr", 64'(mem_addr), 64'd12);
    redirect = 1'b1; redirect_pc = 16'd20; instr_ready = 1'b1;
    step();
    redirect = 1'b0;
    check("rd_flush_valid", 64'(instr_valid), 64'd0);
    check("rd_addr", 64'(mem_addr), 64'd20);
    expect_instr(16'd20, 3'd6, 48'h000000080681);
    expect_instr(16'd26, 3'd2, 48'h000000000000);
    check("halt_set", 64'(halted), 64'd1);
    check("halt_addr", 64'(mem_addr), 64'd28);

    // Halt release via redirect
    redirect = 1'b1; redirect_pc = 16'd12;
    step();
    redirect = 1'b0;
    check("rel_halted", 64'(halted), 64'd0);
    check("rel_addr", 64'(mem_addr), 64'd12);
    expect_instr(16'd12, 3'd6, 48'h0000002A0005);

    // PC wrap at top of memory
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    step();
    check("wrap_addr", 64'(mem_addr), 64'd0);
    expect_instr(16'hFFFE, 3'd2, 48'h000000000008);
    expect_instr(16'd0,    3'd6, 48'h0000FFF80641);

    // Reset mid-run, asserted together with a redirect
    instr_ready = 1'b0;
    step();
    check("mid_nonempty", 64'(instr_valid), 64'd1);
    check("mid_not_halted", 64'(halted), 64'd0);
    redirect = 1'b1; redirect_pc = 16'd20;
    do_reset();
    redirect = 1'b0;
    check("mid_valid", 64'(instr_valid), 64'd0);
    check("mid_addr", 64'(mem_addr), 64'd0);
    check("mid_halted", 64'(halted), 64'd0);
    instr_ready = 1'b1;
    expect_instr(16'd0, 3'd6, 48'h0000FFF80641);
    expect_instr(16'd6, 3'd6, 48'h000000080685);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction fetch stage directly upstream of the decoder. Drives the address port of the byte-addressed unified RAM and consumes its combinational 64-bit little-endian read data.
- Determines the length of each variable-length instruction (2 or 6 bytes) and advances the PC.
- Buffers fetched instructions in a small FIFO toward decode with a valid/ready handshake. Supports redirect (branch/jump) and halt.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- DEPTH, 2, instruction queue entries (power of 2, >=2).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- mem_addr  out  16  RAM byte address. Equals the PC register combinationally.
- mem_q  in  64  RAM read data. Byte k of the word is at mem_addr+k.
- mem_busy  in  1  execute stage owns the RAM address this cycle. No fetch is performed.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  16  new PC.
- instr  out  48  head-of-queue instruction, byte 0 (opcode) in [7:0].
- instr_len  out  3  length of head instruction: 2 or 6.
- instr_pc  out  16  address of head instruction.
- instr_valid  out  1  queue non-empty.
- instr_ready  in  1  decoder accepts the head this cycle.
- halted  out  1  halt opcode fetched. Fetch is stopped.

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC, queue empty, halted=0.
  - instr, instr_len and instr_pc read 0 while empty; instr_valid=0.
  - Reset overrides redirect and any other input.
- Opcode decode:
  - op=mem_q[7:0].
  - len=6 when op[0]=1, else len=2.
  - op==8'h00 is HALT (len 2).
- Fetch condition F = !rst & !redirect & !mem_busy & !halted & !full.
  - full is taken from the registered count only. No bypass: a pop in the same cycle does not free a slot for a push that cycle.
- On F at posedge:
  - Push {instr, len, pc} into the queue.
  - For len=6, instr=mem_q[47:0].
  - For len=2, instr={32'h0, mem_q[15:0]}.
  - pc <= pc+len, modulo 2^16 (0xFFFE+2 wraps to 0x0000).
  - If op==0x00, halted <= 1. The HALT instruction itself is still pushed.
- Fetch-to-output latency: an instruction fetched at edge N is visible (instr_valid=1) in the cycle after edge N, provided the queue was empty.
- Pop: when instr_valid & instr_ready at posedge (and not rst/redirect), the head advances. Push and pop may occur in the same cycle when not full. Count is unchanged and order is preserved.
- Queue outputs come directly from registers (head entry). There is no combinational path from mem_q to instr.
- Redirect (redirect=1 at posedge, rst=0):
  - Queue flushed (count=0), pc <= redirect_pc, halted <= 0.
  - No push occurs that cycle. A concurrent pop is discarded, since the head is flushed.
  - Fetch resumes at the next edge.
- mem_busy=1: pc is held and nothing is pushed. Pops continue.
- Halted: pc is held. The queue keeps draining. Only a redirect or reset clears halted.
- Memory-top boundary: fetch is defined only where pc+5 <= 0xFFFF. Bytes past 0xFFFF are don't-care.

Test Plan:
- Program run: RAM bytes 0..27 = 41 06 F8 FF 00 00 | 85 06 08 00 00 00 | 05 00 2A 00 00 00 | 08 00 | 81 06 08 00 00 00 | 00 00. Hold instr_ready=1 from reset. Required output sequence (pc, len, instr):
  - (0, 6, 0000FFF80641)
  - (6, 6, 000000080685)
  - (12, 6, 0000002A0005)
  - (18, 2, 000000000008)
  - (20, 6, 000000080681)
  - (26, 2, 000000000000), after which halted=1 and mem_addr holds at 28.
- Backpressure: same program with instr_ready=0 → after 2 fetches the queue is full and mem_addr holds at 12. Raise instr_ready → entries from pc 0 and pc 6 come out in order, then pc 12, with no duplicates.
- mem_busy: assert mem_busy for 3 cycles starting while mem_addr=6 → mem_addr stays at 6 for those cycles. The instruction at pc 6 is pushed exactly once, after mem_busy drops.
- Redirect: with 2 entries queued, pulse redirect with redirect_pc=20 together with instr_ready=1 → the next cycle has instr_valid=0 and mem_addr=20. The next delivered instruction is (20, 6, 000000080681).
- Halt release: after HALT at 26, pulse redirect with redirect_pc=12 → halted clears and fetch restarts at 12.
- Reset mid-run: assert rst with the queue non-empty and halted=0 → the next cycle has instr_valid=0, mem_addr=RESET_PC, halted=0, and the output sequence restarts from pc 0.
